// File: rtl/pipelined_cla_addsub_if.sv
// Handshake bundle for pipelined_cla_addsub.
// Operand side : in_valid/in_ready, a, b, sub, c_in
// Result side  : out_valid/out_ready, sum, c_out, overflow, zero, negative
// master = operand source / result consumer; slave = the adder/subtractor.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, sub, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, sub, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, zero, negative
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined adder/subtractor on a two-level carry-lookahead tree.
// Stage 1 registers bit propagate/generate and 4-bit group P/G; stage 2
// resolves group carries with a flat second-level lookahead, forms the sum
// and the status flags, and registers them as the result beat.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of pipelined_cla_addsub_if (operands in, result out)
// WIDTH must be 8, 12 or 16 (2..4 groups of four bits).
module pipelined_cla_addsub #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_cla_addsub_if.slave  bus
);
    localparam int NG  = WIDTH / 4;
    localparam int MSB = WIDTH - 1;

    // Stage-1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
    logic [NG-1:0]    gp_q, gp_d, gg_q, gg_d;
    logic             c0_q, c0_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;

    // Output state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d, overflow_q, overflow_d;
    logic             zero_q, zero_d, negative_q, negative_d;

    logic             s2_adv, in_ready, accept;
    logic [WIDTH-1:0] b_cond, p_new, g_new;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] carry, sum_new;

    assign s2_adv   = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = bus.in_valid && in_ready;

    // Operand conditioning and stage-1 next state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        g_d        = g_q;
        gp_d       = gp_q;
        gg_d       = gg_q;
        c0_d       = c0_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;

        // Subtraction is A + ~B + 1; c_in plays no part in it.
        b_cond = bus.sub ? ~bus.b : bus.b;
        p_new  = bus.a ^ b_cond;
        g_new  = bus.a & b_cond;

        if (accept) begin
            s1_valid_d = 1'b1;
            p_d        = p_new;
            g_d        = g_new;
            c0_d       = bus.sub | bus.c_in;
            a_msb_d    = bus.a[MSB];
            b_msb_d    = b_cond[MSB];
            for (int k = 0; k < NG; k++) begin
                gp_d[k] = &p_new[4*k +: 4];
                gg_d[k] = g_new[4*k+3]
                        | (p_new[4*k+3] & g_new[4*k+2])
                        | (p_new[4*k+3] & p_new[4*k+2] & g_new[4*k+1])
                        | (p_new[4*k+3] & p_new[4*k+2] & p_new[4*k+1] & g_new[4*k]);
            end
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage-2 carry resolution and output next state.
    always_comb begin
        logic acc;
        logic prod;
        grp_c    = '0;
        carry    = '0;
        grp_c[0] = c0_q;

        // Second level: each group carry is a flat sum of products over all
        // lower groups, so no carry ripples from one group to the next.
        for (int k = 0; k < NG; k++) begin
            acc  = gg_q[k];
            prod = gp_q[k];
            for (int j = k - 1; j >= 0; j--) begin
                acc  = acc | (prod & gg_q[j]);
                prod = prod & gp_q[j];
            end
            grp_c[k+1] = acc | (prod & c0_q);
        end

        // First level: carries inside a group from that group's carry-in.
        for (int k = 0; k < NG; k++) begin
            carry[4*k]   = grp_c[k];
            carry[4*k+1] = g_q[4*k] | (p_q[4*k] & grp_c[k]);
            carry[4*k+2] = g_q[4*k+1] | (p_q[4*k+1] & g_q[4*k])
                         | (p_q[4*k+1] & p_q[4*k] & grp_c[k]);
            carry[4*k+3] = g_q[4*k+2] | (p_q[4*k+2] & g_q[4*k+1])
                         | (p_q[4*k+2] & p_q[4*k+1] & g_q[4*k])
                         | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & grp_c[k]);
        end
        sum_new = p_q ^ carry;

        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;

        if (s2_adv) begin
            out_valid_d = 1'b1;
            sum_d       = sum_new;
            c_out_d     = grp_c[NG];
            overflow_d  = (a_msb_q == b_msb_q) && (sum_new[MSB] != a_msb_q);
            zero_d      = ~|sum_new;
            negative_d  = sum_new[MSB];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            p_q         <= '0;
            g_q         <= '0;
            gp_q        <= '0;
            gg_q        <= '0;
            c0_q        <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            p_q         <= p_d;
            g_q         <= g_d;
            gp_q        <= gp_d;
            gg_q        <= gg_d;
            c0_q        <= c0_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
endmodule
